// File: rtl/ultrasound_scheduler_if.sv
// Pin-side bundle of the ultrasound ranging scheduler: sensor pins plus result outputs.
// master = pet logic / sensor side, slave = the scheduler itself.
interface ultrasound_scheduler_if;
   logic        enable;
   logic        echo;
   logic        trigger;
   logic        busy;
   logic        distance_valid;
   logic        timeout;
   logic [21:0] echo_cycles;
   logic        object_detected;

   modport master (
      output enable, echo,
      input  trigger, busy, distance_valid, timeout, echo_cycles, object_detected
   );

   modport slave (
      input  enable, echo,
      output trigger, busy, distance_valid, timeout, echo_cycles, object_detected
   );
endinterface

// File: rtl/ultrasound_scheduler.sv
// Periodic HC-SR04 ranging: trigger pulse, echo width measurement with timeout,
// near/far hysteresis on object_detected.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no measurement; waits for enable
// TRIG      | trigger pin high for TRIG_CYCLES
// WAIT_RISE | waiting for echo_s rising edge, bounded by ECHO_TIMEOUT
// MEASURE   | counting echo_s high cycles, bounded by ECHO_TIMEOUT
// HOLDOFF   | result reported; waits out the rest of the period
module ultrasound_scheduler #(
   parameter int TRIG_CYCLES   = 500,
   parameter int PERIOD_CYCLES = 3_000_000,
   parameter int ECHO_TIMEOUT  = 1_250_000,
   parameter int NEAR_CYCLES   = 58_000,
   parameter int HITS          = 3
) (
   input logic                   clk,
   input logic                   rst,
   ultrasound_scheduler_if.slave us_if
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_TRIG = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_MEAS = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;

   localparam logic [21:0] TRIG_LAST = 22'(TRIG_CYCLES - 1);
   localparam logic [21:0] TO_LAST   = 22'(ECHO_TIMEOUT - 1);
   localparam logic [21:0] TO_VAL    = 22'(ECHO_TIMEOUT);
   localparam logic [21:0] PER_LAST  = 22'(PERIOD_CYCLES - 1);
   localparam logic [21:0] NEAR_V    = 22'(NEAR_CYCLES);
   localparam logic [3:0]  RUN_LAST  = 4'(HITS - 1);

   logic [2:0]  state_q, state_d;
   logic [21:0] cnt_q, cnt_d;
   logic [21:0] per_q, per_d;
   logic [21:0] cyc_q, cyc_d;
   logic [3:0]  run_q, run_d;
   logic        echo_m_q, echo_s_q, echo_p_q;
   logic        trig_q, trig_d;
   logic        dv_q, dv_d;
   logic        to_q, to_d;
   logic        obj_q, obj_d;
   logic        finish_to;
   logic        rise;
   logic        hit;

   assign rise = echo_s_q & ~echo_p_q;
   assign hit  = ~to_q && (cyc_q <= NEAR_V);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      dv_d      = 1'b0;
      to_d      = 1'b0;
      finish_to = 1'b0;
      per_d     = (state_q == ST_IDLE || per_q == '1) ? per_q : per_q + 22'd1;

      case (state_q)
         ST_IDLE: begin
            if (us_if.enable) begin
               state_d = ST_TRIG;
               per_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_TRIG: begin
            if (cnt_q >= TRIG_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 22'd1;
            end
         end
         ST_WAIT: begin
            if (rise) begin
               state_d = ST_MEAS;
               cnt_d   = 22'd1;
            end else if (cnt_q >= TO_LAST) begin
               finish_to = 1'b1;
            end else begin
               cnt_d = cnt_q + 22'd1;
            end
         end
         ST_MEAS: begin
            if (!echo_s_q) begin
               cyc_d   = cnt_q;
               dv_d    = 1'b1;
               state_d = ST_HOLD;
            end else if (cnt_q >= TO_LAST) begin
               finish_to = 1'b1;
            end else begin
               cnt_d = cnt_q + 22'd1;
            end
         end
         ST_HOLD: begin
            // >= also covers a period shorter than the measurement window
            if (per_q >= PER_LAST) begin
               if (us_if.enable) begin
                  state_d = ST_TRIG;
                  per_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (finish_to) begin
         cyc_d   = TO_VAL;
         dv_d    = 1'b1;
         to_d    = 1'b1;
         state_d = ST_HOLD;
      end

      trig_d = (state_d == ST_TRIG);

      // Hysteresis acts on the registered result, one cycle after distance_valid
      obj_d = obj_q;
      run_d = run_q;
      if (dv_q) begin
         if (hit != obj_q) begin
            if (run_q >= RUN_LAST) begin
               obj_d = ~obj_q;
               run_d = '0;
            end else if (run_q != 4'hf) begin
               run_d = run_q + 4'd1;
            end
         end else begin
            run_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         per_q    <= '0;
         cyc_q    <= '0;
         run_q    <= '0;
         echo_m_q <= 1'b0;
         echo_s_q <= 1'b0;
         echo_p_q <= 1'b0;
         trig_q   <= 1'b0;
         dv_q     <= 1'b0;
         to_q     <= 1'b0;
         obj_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         cyc_q    <= cyc_d;
         run_q    <= run_d;
         echo_m_q <= us_if.echo;
         echo_s_q <= echo_m_q;
         echo_p_q <= echo_s_q;
         trig_q   <= trig_d;
         dv_q     <= dv_d;
         to_q     <= to_d;
         obj_q    <= obj_d;
      end
   end

   assign us_if.trigger         = trig_q;
   assign us_if.busy            = (state_q == ST_TRIG) || (state_q == ST_WAIT) || (state_q == ST_MEAS);
   assign us_if.distance_valid  = dv_q;
   assign us_if.timeout         = to_q;
   assign us_if.echo_cycles     = cyc_q;
   assign us_if.object_detected = obj_q;

endmodule

// File: tb/tb_ultrasound_scheduler.sv
// Randomized self-checking bench for ultrasound_scheduler against a result-level reference model.
module tb_ultrasound_scheduler;

   localparam int TRIG   = 5;
   localparam int PERIOD = 200;
   localparam int TMO    = 60;
   localparam int NEAR   = 20;
   localparam int NHITS  = 2;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cycle_no;
   int   rise_now;
   int   rise_prev;
   logic obj_m;
   int   run_m;

   ultrasound_scheduler_if bus ();

   ultrasound_scheduler #(
      .TRIG_CYCLES  (TRIG),
      .PERIOD_CYCLES(PERIOD),
      .ECHO_TIMEOUT (TMO),
      .NEAR_CYCLES  (NEAR),
      .HITS         (NHITS)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .us_if(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_no <= cycle_no + 1;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One full measurement: d = echo start (cycles after trigger fall), w = echo width
   // (0 = no echo), stuck = echo high from before the trigger.
   task automatic run_meas(input int d, input int w, input bit stuck, input int drop_k,
                           input bit chk_space);
      int          k;
      int          hi;
      int          lat;
      logic        exp_to;
      logic [21:0] exp_c;
      int          exp_lat;
      logic        hit;
      if (stuck) bus.echo = 1'b1;
      k = 0;
      while (bus.trigger !== 1'b1 && k < 400) begin
         step(1);
         k++;
      end
      total++;
      if (bus.trigger !== 1'b1) begin
         bad++;
         $display("FAIL trig_start: trigger=%b, wanted 1 within 400 cycles", bus.trigger);
         bus.echo = 1'b0;
         return;
      end
      rise_prev = rise_now;
      rise_now  = cycle_no;
      if (chk_space) begin
         total++;
         if (rise_now - rise_prev != PERIOD) begin
            bad++;
            $display("FAIL trig_spacing: got %0d, wanted %0d", rise_now - rise_prev, PERIOD);
         end
      end
      hi = 0;
      while (bus.trigger === 1'b1 && hi < 50) begin
         step(1);
         hi++;
      end
      total++;
      if (hi != TRIG) begin
         bad++;
         $display("FAIL trig_width: got %0d, wanted %0d", hi, TRIG);
      end
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_wait: got %b, wanted 1", bus.busy);
      end

      if (stuck || w == 0) begin
         exp_to = 1'b1; exp_c = 22'(TMO); exp_lat = TMO;
      end else if (w >= TMO) begin
         exp_to = 1'b1; exp_c = 22'(TMO); exp_lat = -1;
      end else begin
         exp_to = 1'b0; exp_c = 22'(w); exp_lat = d + w + 3;
      end

      k = 0;
      lat = -1;
      while (k < 250) begin
         if (bus.distance_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (!stuck && w > 0 && k == d) bus.echo = 1'b1;
         if (!stuck && w > 0 && k == d + w) bus.echo = 1'b0;
         if (k == drop_k) bus.enable = 1'b0;
         step(1);
         k++;
      end
      total++;
      if (lat < 0) begin
         bad++;
         $display("FAIL dv_missing: no distance_valid within 250 cycles (w=%0d)", w);
         bus.echo = 1'b0;
         return;
      end
      if (exp_lat >= 0) begin
         total++;
         if (lat != exp_lat) begin
            bad++;
            $display("FAIL dv_latency: got %0d, wanted %0d (d=%0d w=%0d)", lat, exp_lat, d, w);
         end
      end
      total++;
      if (bus.timeout !== exp_to) begin
         bad++;
         $display("FAIL timeout_flag: got %b, wanted %b (w=%0d)", bus.timeout, exp_to, w);
      end
      total++;
      if (bus.echo_cycles !== exp_c) begin
         bad++;
         $display("FAIL echo_cycles: got %0d, wanted %0d (w=%0d)", bus.echo_cycles, exp_c, w);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_hold: got %b, wanted 0", bus.busy);
      end

      hit = !exp_to && (exp_c <= 22'(NEAR));
      if (hit != obj_m) begin
         run_m++;
         if (run_m >= NHITS) begin
            obj_m = !obj_m;
            run_m = 0;
         end
      end else begin
         run_m = 0;
      end
      step(1);
      k++;
      total++;
      if (bus.object_detected !== obj_m) begin
         bad++;
         $display("FAIL object_detected: got %b, wanted %b (w=%0d)", bus.object_detected, obj_m, w);
      end
      while (!stuck && w > 0 && k < d + w) begin
         step(1);
         k++;
      end
      bus.echo = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      obj_m = 1'b0;
      run_m = 0;
   endtask

   task automatic test_reset();
      int trig_hi;
      int dv_hi;
      bus.enable = 1'b0;
      bus.echo   = 1'b0;
      rst = 1'b1;
      step(3);
      total++;
      if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_trig_busy: trigger=%b busy=%b, wanted 0 0", bus.trigger, bus.busy);
      end
      total++;
      if (bus.distance_valid !== 1'b0 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_pulses: dv=%b timeout=%b, wanted 0 0", bus.distance_valid, bus.timeout);
      end
      total++;
      if (bus.echo_cycles !== 22'd0 || bus.object_detected !== 1'b0) begin
         bad++;
         $display("FAIL reset_result: echo_cycles=%0d obj=%b, wanted 0 0",
                  bus.echo_cycles, bus.object_detected);
      end
      rst = 1'b0;
      obj_m = 1'b0;
      run_m = 0;
      trig_hi = 0;
      dv_hi = 0;
      for (int i = 0; i < 500; i++) begin
         step(1);
         if (bus.trigger === 1'b1) trig_hi++;
         if (bus.distance_valid === 1'b1) dv_hi++;
      end
      total++;
      if (trig_hi != 0 || dv_hi != 0) begin
         bad++;
         $display("FAIL idle_quiet: trigger high %0d, dv high %0d cycles, wanted 0 0", trig_hi, dv_hi);
      end
   endtask

   task automatic test_single();
      bus.enable = 1'b1;
      run_meas(8, 10, 1'b0, -1, 1'b0);
      run_meas(8, 10, 1'b0, -1, 1'b1);
   endtask

   task automatic test_hysteresis();
      int   widths [6];
      logic want   [6];
      widths = '{10, 10, 40, 10, 40, 40};
      want   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         run_meas(8, widths[i], 1'b0, -1, i > 0);
         total++;
         if (bus.object_detected !== want[i]) begin
            bad++;
            $display("FAIL hyst_table[%0d]: got %b, wanted %b", i, bus.object_detected, want[i]);
         end
      end
   endtask

   task automatic test_timeouts();
      run_meas(0, 0, 1'b0, -1, 1'b1);
      run_meas(8, 100, 1'b0, -1, 1'b1);
      run_meas(0, 0, 1'b1, -1, 1'b1);
   endtask

   task automatic test_boundary();
      int widths [6];
      widths = '{59, 20, 20, 21, 21, 1};
      for (int i = 0; i < 6; i++) run_meas(5, widths[i], 1'b0, -1, 1'b1);
   endtask

   task automatic test_random();
      int d;
      int w;
      for (int i = 0; i < 12; i++) begin
         d = int'($urandom_range(0, 40));
         w = int'($urandom_range(0, 75));
         run_meas(d, w, 1'b0, -1, 1'b1);
      end
   endtask

   task automatic test_enable_drop();
      int trig_hi;
      run_meas(8, 20, 1'b0, 15, 1'b1);
      trig_hi = 0;
      for (int i = 0; i < 500; i++) begin
         step(1);
         if (bus.trigger === 1'b1) trig_hi++;
      end
      total++;
      if (trig_hi != 0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL enable_drop: trigger high %0d cycles busy=%b, wanted 0 0", trig_hi, bus.busy);
      end
   endtask

   task automatic test_rst_midflight();
      int k;
      bus.enable = 1'b1;
      k = 0;
      while (bus.trigger !== 1'b1 && k < 50) begin
         step(1);
         k++;
      end
      total++;
      if (bus.trigger !== 1'b1) begin
         bad++;
         $display("FAIL restart_trig: trigger=%b, wanted 1 within 50 cycles", bus.trigger);
      end
      step(2);
      rst = 1'b1;
      bus.enable = 1'b0;
      step(1);
      rst = 1'b0;
      total++;
      if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_in_trig: trigger=%b busy=%b, wanted 0 0", bus.trigger, bus.busy);
      end
      total++;
      if (bus.object_detected !== 1'b0 || bus.echo_cycles !== 22'd0) begin
         bad++;
         $display("FAIL rst_result: obj=%b echo_cycles=%0d, wanted 0 0",
                  bus.object_detected, bus.echo_cycles);
      end
      step(20);
      total++;
      if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_rst: trigger=%b busy=%b, wanted 0 0", bus.trigger, bus.busy);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      cycle_no = 0;
      rise_now = 0;
      rise_prev = 0;
      obj_m = 1'b0;
      run_m = 0;
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.echo = 1'b0;
      test_reset();
      test_single();
      test_hysteresis();
      test_timeouts();
      test_boundary();
      test_random();
      test_enable_drop();
      test_rst_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ultrasound_scheduler.md
# ultrasound_scheduler

Periodic ranging controller for the HC-SR04-style ultrasound sensor. It fires the trigger pulse on a fixed schedule and measures the echo pulse width in clock cycles, with a timeout. Each result is compared against a near threshold, and `object_detected` is held through a consecutive-hit/miss hysteresis. It sits between the sensor pins and the pet logic, which uses `object_detected` as a "someone is near" stimulus.

## Interface
- `TRIG_CYCLES`, 500: trigger high time in clocks (10 µs at 50 MHz).
- `PERIOD_CYCLES`, 3_000_000: clocks from one trigger start to the next (60 ms).
- `ECHO_TIMEOUT`, 1_250_000: maximum wait for the echo rise, and separately the maximum echo width.
- `NEAR_CYCLES`, 58_000: echo width at or below this counts as a hit (about 20 cm).
- `HITS`, 3: number of consecutive hits to set `object_detected`, or consecutive misses to clear it. Range 1..15.
- `clk`, in, 1: 50 MHz system clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `enable`, in, 1: allows new measurement cycles.
- `echo`, in, 1: sensor echo. Asynchronous; goes through a 2-flop synchronizer (`echo_s`) inside the block.
- `trigger`, out, 1: sensor trigger, registered.
- `busy`, out, 1: high in TRIG, WAIT_RISE and MEASURE.
- `distance_valid`, out, 1: one-cycle pulse when a measurement completes.
- `timeout`, out, 1: one-cycle pulse coincident with `distance_valid` when the measurement timed out.
- `echo_cycles`, out, 22: last measured width. Holds its value between results.
- `object_detected`, out, 1: output after hysteresis.

## Operation
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: `trigger`=0. If `enable`=1, go to TRIG next cycle and clear the period counter.
- TRIG: `trigger`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. Clear the timeout counter.
- WAIT_RISE: wait for a rising edge of `echo_s` (current 1, previous 0).
  - On the edge, go to MEASURE with the width counter set to 1.
  - If `ECHO_TIMEOUT` cycles elapse with no edge, finish as a timeout.
  - An echo already high on entry (stuck high) is not an edge. It ends in a timeout.
- MEASURE: the width counter increments each cycle `echo_s`=1.
  - On `echo_s`=0, latch the count into `echo_cycles`, pulse `distance_valid`, and go to HOLDOFF.
  - If the count reaches `ECHO_TIMEOUT`, finish as a timeout.
- Timeout finish: `echo_cycles` ← `ECHO_TIMEOUT`. Pulse `distance_valid` and `timeout` together, then go to HOLDOFF.
- HOLDOFF: when the period counter reaches `PERIOD_CYCLES`-1, go to TRIG if `enable`=1, otherwise to IDLE.
  - If that count has already passed (parameters violate the constraint below), exit on the next cycle.
- Parameter constraint: `PERIOD_CYCLES` ≥ `TRIG_CYCLES` + 2·`ECHO_TIMEOUT` + 8.
- `enable` is sampled only when leaving IDLE or HOLDOFF. A measurement in progress always completes.
- Hit rule: a result is a hit when it is not a timeout and `echo_cycles` ≤ `NEAR_CYCLES`. A timeout is a miss.
- Hysteresis uses a 4-bit run counter of same-kind results opposite to the current `object_detected`.
  - When the run reaches `HITS`, toggle `object_detected` and clear the counter.
  - A result that agrees with the current state clears the counter.
- Counters saturate. The period counter counts in every state except IDLE and never wraps.

## Timing
- Reset values:
  - `trigger`, `busy`, `distance_valid`, `timeout`, `object_detected` = 0.
  - `echo_cycles` = 0.
  - State = IDLE; synchronizer, hysteresis and all other counters = 0.
- `rst` asserted mid-operation returns the block to IDLE on the next edge, with `trigger` low that same edge.
- Trigger start is 1 cycle after `enable` is seen in IDLE.
- Echo edges reach the FSM 2 cycles after the input changes.
- Synchronous echo held high for exactly N clocks (N < `ECHO_TIMEOUT`) gives `echo_cycles` = N.
- `distance_valid` goes high on the cycle after `echo_s` is first seen low. `echo_cycles` is valid in that same cycle.
- `object_detected` updates 1 cycle after the `distance_valid` of the deciding result.
- Trigger starts are spaced exactly `PERIOD_CYCLES` apart while `enable`=1.

## Test plan
Parameter overrides for all scenarios: `TRIG_CYCLES`=5, `PERIOD_CYCLES`=200, `ECHO_TIMEOUT`=60, `NEAR_CYCLES`=20, `HITS`=2.
- Reset/idle: `rst` for 3 cycles with `enable`=0 → all outputs 0, `trigger` never rises over 500 cycles.
- Single measurement: `enable`=1, echo high 10 clocks starting 8 clocks after the trigger falls → `trigger` high exactly 5 cycles; `distance_valid` pulse with `echo_cycles`=10, `timeout`=0; next trigger rises 200 cycles after the first.
- Hysteresis set/clear: echo widths 10, 10, 40, 10, 40, 40 → `object_detected` rises after the 2nd result, stays high through the 3rd and 4th, falls after the 6th.
- No echo: echo held 0 → `timeout` and `distance_valid` pulse 60 cycles after the trigger falls, `echo_cycles`=60, counted as a miss.
- Long or stuck echo: echo high 100 clocks → timeout at width 60, `echo_cycles`=60. Echo stuck high from before the trigger → WAIT_RISE timeout.
- Enable and reset mid-flight: drop `enable` during MEASURE → result still reported, then IDLE with no further triggers. Assert `rst` during TRIG → `trigger` low on the next edge and state IDLE.
